imem_load_ctrl: RTL and testbench

Owns the single address port of the 256x32 instruction memory and shares it between CPU fetch and a byte-wide program loader. In RUN it passes the PC through as the fetch address and returns the fetched word. On a load command it stalls the CPU, assembles incoming bytes into 32-bit words and writes them from address 0 upward. It then flushes the pipeline with NOPs and clears the PC so execution restarts at address 0.

---
 rtl/imem_pkg.sv | 17 +
 rtl/imem_load_ctrl_byte_packer.sv | 35 +++
 rtl/imem_load_ctrl.sv | 123 ++++++++++++
 tb/tb_imem_load_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// Shared constants and state encoding for the instruction-memory load controller.
package imem_pkg;

  localparam int ADDR_W         = 8;
  localparam int DATA_W         = 32;
  localparam int BYTES_PER_WORD = DATA_W / 8;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    COLLECT = 2'd1,
    WRITE   = 2'd2,
    FLUSH   = 2'd3
  } state_e;

  localparam logic [DATA_W-1:0] NOP_WORD = '0;

endpackage

// File: rtl/imem_load_ctrl_byte_packer.sv
// Assembles loader bytes into a word, most significant byte first.
// word_done marks the cycle in which the final byte of a word is accepted.
module byte_packer #(
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic              accept,
  input  logic [7:0]        data_byte,
  output logic [DATA_W-1:0] shift,
  output logic              word_done
);

  localparam int BPW   = DATA_W / 8;
  localparam int CNT_W = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BPW - 1);

  logic [CNT_W-1:0] byte_cnt;

  assign word_done = accept && (byte_cnt == LAST);

  always_ff @(posedge clock) begin
    if (reset) begin
      byte_cnt <= '0;
      shift    <= '0;
    end else if (clear) begin
      byte_cnt <= '0;
    end else if (accept) begin
      shift    <= (shift << 8) | DATA_W'(data_byte);
      byte_cnt <= word_done ? '0 : byte_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/imem_load_ctrl.sv
// Shares the instruction-memory port between CPU fetch and a byte-wide loader.
//   state   | meaning
//   RUN     | PC drives the memory, fetched word goes to the CPU
//   COLLECT | CPU stalled, gathering loader bytes into a word
//   WRITE   | one-cycle memory write of the assembled word
//   FLUSH   | NOPs into the pipeline, PC cleared on the last cycle
module imem_load_ctrl #(
  parameter int ADDR_W       = imem_pkg::ADDR_W,
  parameter int DATA_W       = imem_pkg::DATA_W,
  parameter int FLUSH_CYCLES = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] instr_out,
  output logic              cpu_stall,
  output logic              pc_clear,
  input  logic              ld_start,
  input  logic [ADDR_W:0]   ld_len,
  input  logic [7:0]        ld_byte,
  input  logic              ld_byte_valid,
  output logic              ld_byte_ready,
  output logic              ld_busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
);

  import imem_pkg::*;

  localparam logic [ADDR_W:0] MAX_LEN    = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE_LEFT   = (ADDR_W+1)'(1);
  localparam logic [3:0]      FLUSH_LAST = 4'(FLUSH_CYCLES - 1);

  state_e              state, state_nxt;
  logic [ADDR_W-1:0]   word_addr;
  logic [ADDR_W:0]     words_left;
  logic [3:0]          flush_cnt;
  logic [DATA_W-1:0]   shift;
  logic                start_ok, accept, word_done, flush_last, load_begin;

  // Zero-length and oversize commands are dropped without leaving RUN.
  assign start_ok   = ld_start && (ld_len != '0) && (ld_len <= MAX_LEN);
  assign load_begin = (state == RUN) && start_ok;
  assign accept     = (state == COLLECT) && ld_byte_valid;
  assign flush_last = (flush_cnt == FLUSH_LAST);

  byte_packer #(.DATA_W(DATA_W)) u_packer (
    .clock     (clock),
    .reset     (reset),
    .clear     (load_begin),
    .accept    (accept),
    .data_byte (ld_byte),
    .shift     (shift),
    .word_done (word_done)
  );

  always_ff @(posedge clock) begin
    if (reset) state <= RUN;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    mem_addr      = word_addr;
    instr_out     = DATA_W'(NOP_WORD);
    mem_we        = 1'b0;
    cpu_stall     = 1'b1;
    ld_byte_ready = 1'b0;
    pc_clear      = 1'b0;
    case (state)
      RUN: begin
        mem_addr  = pc;
        instr_out = mem_rdata;
        cpu_stall = 1'b0;
        if (start_ok) state_nxt = COLLECT;
      end
      COLLECT: begin
        ld_byte_ready = 1'b1;
        if (word_done) state_nxt = WRITE;
      end
      WRITE: begin
        mem_we    = 1'b1;
        state_nxt = (words_left == ONE_LEFT) ? FLUSH : COLLECT;
      end
      FLUSH: begin
        pc_clear = flush_last;
        if (flush_last) state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  assign mem_wdata = shift;
  assign ld_busy   = (state != RUN);

  // word_addr wraps to 0 after a full-depth load; harmless since FLUSH follows.
  always_ff @(posedge clock) begin
    if (reset) begin
      word_addr  <= '0;
      words_left <= '0;
      flush_cnt  <= '0;
    end else begin
      case (state)
        RUN: begin
          if (start_ok) begin
            word_addr  <= '0;
            words_left <= ld_len;
          end
        end
        WRITE: begin
          word_addr  <= word_addr + 1'b1;
          words_left <= words_left - 1'b1;
          flush_cnt  <= '0;
        end
        FLUSH: flush_cnt <= flush_cnt + 4'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_load_ctrl.sv
// Self-checking bench for imem_load_ctrl with a behavioural 256x32 memory
// and a write scoreboard fed by the loader stimulus.
`timescale 1ns/1ps
module tb_imem_load_ctrl;

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] data;
  } wr_t;

  logic        clock = 1'b0;
  logic        reset;
  logic [7:0]  pc;
  logic [31:0] instr_out;
  logic        cpu_stall, pc_clear;
  logic        ld_start;
  logic [8:0]  ld_len;
  logic [7:0]  ld_byte;
  logic        ld_byte_valid, ld_byte_ready, ld_busy;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic        mem_we;

  logic [31:0] mem [256];
  wr_t         exp_q[$];
  int          checks = 0;
  int          failures = 0;
  int          wr_count = 0;
  int          cyc = 0;
  logic        stall_watch = 1'b0;
  logic        stall_drop = 1'b0;

  imem_load_ctrl dut (
    .clock         (clock),
    .reset         (reset),
    .pc            (pc),
    .instr_out     (instr_out),
    .cpu_stall     (cpu_stall),
    .pc_clear      (pc_clear),
    .ld_start      (ld_start),
    .ld_len        (ld_len),
    .ld_byte       (ld_byte),
    .ld_byte_valid (ld_byte_valid),
    .ld_byte_ready (ld_byte_ready),
    .ld_busy       (ld_busy),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_we        (mem_we),
    .mem_rdata     (mem_rdata)
  );

  always #5 clock = ~clock;

  assign mem_rdata = mem[mem_addr];
  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (mem_we) mem[mem_addr] <= mem_wdata;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clock) begin
    if (!reset && mem_we) begin
      wr_count++;
      if (exp_q.size() == 0) begin
        check("write_unexpected", 64'(mem_addr), 64'hFFFF);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_addr", 64'(mem_addr), 64'(e.addr));
        check("wr_data", 64'(mem_wdata), 64'(e.data));
      end
    end
    if (stall_watch && !cpu_stall) stall_drop = 1'b1;
  end

  task automatic start_load(input logic [8:0] len);
    ld_start = 1'b1;
    ld_len   = len;
    @(posedge clock); #1;
    ld_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit throttle);
    int t;
    if (throttle) begin
      ld_byte_valid = 1'b0;
      @(posedge clock); #1;
    end
    ld_byte_valid = 1'b1;
    ld_byte       = b;
    t = 0;
    @(negedge clock);
    while (!ld_byte_ready && t < 50) begin
      @(negedge clock);
      t++;
    end
    if (t >= 50) check("byte_ready_timeout", 64'(t), 64'd0);
    @(posedge clock); #1;
    ld_byte_valid = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] addr, input logic [31:0] w, input bit throttle);
    exp_q.push_back('{addr: addr, data: w});
    for (int b = 3; b >= 0; b--) send_byte(w[b*8 +: 8], throttle);
  endtask

  task automatic wait_idle(input int limit);
    int t;
    t = 0;
    @(negedge clock);
    while (ld_busy && t < limit) begin
      @(negedge clock);
      t++;
    end
    check("idle_timeout", 64'(ld_busy), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int start_cyc, wr0;
    for (int i = 0; i < 256; i++) mem[i] <= 32'hC000_0000 | i;
    mem[12] <= 32'h4142_0C00;
    reset = 1'b1; pc = 8'd0; ld_start = 1'b0; ld_len = '0;
    ld_byte = '0; ld_byte_valid = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    pc = 8'd12;

    // reset state and fetch pass-through
    @(negedge clock);
    check("rst_stall", 64'(cpu_stall), 0);
    check("rst_pc_clear", 64'(pc_clear), 0);
    check("rst_ready", 64'(ld_byte_ready), 0);
    check("rst_busy", 64'(ld_busy), 0);
    check("rst_we", 64'(mem_we), 0);
    check("run_fetch12", 64'(instr_out), 64'h4142_0C00);
    pc = 8'd13;
    #1 check("run_fetch13", 64'(instr_out), 64'hC000_000D);

    // single-word load with flush timing
    @(posedge clock); #1;
    wr0 = wr_count;
    start_load(9'd1);
    start_cyc = cyc;
    send_word(8'd0, 32'h7104_1000, 1'b0);
    @(negedge clock);
    for (int i = 1; i <= 5; i++) begin
      @(negedge clock);
      check("flush_instr", 64'(instr_out), 0);
      check("flush_stall", 64'(cpu_stall), 1);
      check("flush_pc_clear", 64'(pc_clear), 64'(i == 5));
    end
    @(negedge clock);
    check("post_busy", 64'(ld_busy), 0);
    check("post_pc_clear", 64'(pc_clear), 0);
    check("run_latency", 64'(cyc - start_cyc), 64'd10);
    check("single_wr_cnt", 64'(wr_count - wr0), 1);
    check("mem0_single", 64'(mem[0]), 64'h7104_1000);

    // throttled loader
    @(posedge clock); #1;
    start_load(9'd3);
    stall_watch = 1'b1;
    send_word(8'd0, 32'h1111_2222, 1'b1);
    send_word(8'd1, 32'h3344_5566, 1'b1);
    send_word(8'd2, 32'h7788_99AA, 1'b1);
    stall_watch = 1'b0;
    check("throttle_stall", 64'(stall_drop), 0);
    wait_idle(20);

    // ignored commands
    @(posedge clock); #1;
    start_load(9'd0);
    @(negedge clock);
    check("len0_busy", 64'(ld_busy), 0);
    @(posedge clock); #1;
    start_load(9'h101);
    @(negedge clock);
    check("len257_busy", 64'(ld_busy), 0);

    // second ld_start during COLLECT must not restart the load
    @(posedge clock); #1;
    wr0 = wr_count;
    start_load(9'd2);
    send_word(8'd0, 32'hCAFE_0000, 1'b0);
    @(posedge clock); #1;
    start_load(9'd3);
    @(negedge clock);
    check("restart_busy", 64'(ld_busy), 1);
    @(posedge clock); #1;
    send_word(8'd1, 32'hCAFE_0001, 1'b0);
    wait_idle(20);
    check("restart_wr_cnt", 64'(wr_count - wr0), 2);

    // full-depth load
    @(posedge clock); #1;
    wr0 = wr_count;
    start_load(9'h100);
    for (int i = 0; i < 256; i++) send_word(8'(i), 32'(i), 1'b0);
    wait_idle(20);
    check("full_wr_cnt", 64'(wr_count - wr0), 256);
    check("full_mem0", 64'(mem[0]), 0);
    check("full_mem255", 64'(mem[255]), 255);
    for (int i = 0; i < 256; i += 51) begin
      pc = 8'(i);
      #1 check("full_fetch", 64'(instr_out), 64'(i));
    end

    // reset in the middle of word 1
    @(posedge clock); #1;
    start_load(9'd2);
    send_word(8'd0, 32'hA5A5_0001, 1'b0);
    send_byte(8'hEE, 1'b0);
    send_byte(8'hDD, 1'b0);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    check("mid_rst_busy", 64'(ld_busy), 0);
    check("mid_rst_stall", 64'(cpu_stall), 0);
    check("mid_rst_pc_clear", 64'(pc_clear), 0);
    pc = 8'd0;
    #1 check("mid_rst_mem0", 64'(instr_out), 64'hA5A5_0001);
    pc = 8'd1;
    #1 check("mid_rst_mem1", 64'(instr_out), 64'd1);

    // fresh load after reset must not carry stale bytes
    @(posedge clock); #1;
    start_load(9'd1);
    send_word(8'd0, 32'hDEAD_BEEF, 1'b0);
    wait_idle(20);
    pc = 8'd0;
    #1 check("fresh_mem0", 64'(instr_out), 64'hDEAD_BEEF);
    check("sb_empty", 64'(exp_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
